// File: rtl/color_pack_pkg.sv
// color_pack_pkg
//   Shared types for the RGB pixel path.
//   t_color : one pixel as an unpacked struct of three 8-bit components.
package color_pack_pkg;

  typedef struct {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } t_color;

endpackage

// File: rtl/color_pack.sv
// color_pack
//   Assembles a byte stream of colour components (R, G, B, one per beat)
//   into one t_color pixel per three accepted beats.
//
//   Optional feature macro: COLOR_PACK_SOF_EN
//     When defined, the in_sof input and sof_err output exist and a beat
//     flagged with in_sof always restarts pixel assembly as the R component.
//     When undefined, assembly is a strict R->G->B rotation from reset.
//
// Handshake rule (both sides): a transfer happens on a rising clk edge when
// valid && ready are both high. The source may not depend on in_ready to
// raise in_valid; the sink may not depend on out_valid to raise out_ready.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   in_valid   in   source offers a component byte
//   in_ready   out  byte is accepted this cycle
//   in_data    in   component byte
//   in_sof     in   start of pixel, byte is R       (COLOR_PACK_SOF_EN only)
//   out_valid  out  color holds a complete pixel
//   out_ready  in   sink takes the pixel this cycle
//   color      out  assembled pixel
//   pix_cnt    out  pixels handed off, wraps at 2^CNT_W
//   sof_err    out  one-cycle pulse on a discarded partial pixel
//                                                   (COLOR_PACK_SOF_EN only)
//   state_dbg  out  current assembly state (S_R / S_G / S_B)
module color_pack
  import color_pack_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
`ifdef COLOR_PACK_SOF_EN
  input  logic             in_sof,
  output logic             sof_err,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output t_color           color,
  output logic [CNT_W-1:0] pix_cnt,
  output logic [1:0]       state_dbg
);

  localparam logic [1:0] S_R = 2'd0;
  localparam logic [1:0] S_G = 2'd1;
  localparam logic [1:0] S_B = 2'd2;

  logic [1:0]       state_q,     state_d;
  logic [7:0]       hr_q,        hr_d;
  logic [7:0]       hg_q,        hg_d;
  t_color           color_q,     color_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] pix_cnt_q,   pix_cnt_d;
  logic             sof_err_q,   sof_err_d;

  logic in_acc;
  logic out_xfer;
  logic b_acc;
  logic sof_beat;

`ifdef COLOR_PACK_SOF_EN
  assign sof_beat = in_sof;
`else
  assign sof_beat = 1'b0;
`endif

  // R and G land in holding registers that are independent of color, so
  // they are always accepted. Only the B beat needs room in the output slot,
  // which exists when it is empty or being drained this same cycle. An SOF
  // beat is always stored as R, so it never has to wait.
  always_comb begin
    in_ready = 1'b1;
    if (state_q == S_B && !sof_beat) begin
      in_ready = !out_valid_q || out_ready;
    end
  end

  assign in_acc   = in_valid && in_ready;
  assign out_xfer = out_valid_q && out_ready;

  always_comb begin
    state_d   = state_q;
    hr_d      = hr_q;
    hg_d      = hg_q;
    color_d   = color_q;
    sof_err_d = 1'b0;
    b_acc     = 1'b0;

    if (in_acc) begin
      if (sof_beat) begin
        // Resynchronise: this byte is R of a new pixel; any partial pixel
        // collected so far is thrown away and flagged.
        hr_d      = in_data;
        hg_d      = 8'h00;
        state_d   = S_G;
        sof_err_d = (state_q != S_R);
      end else begin
        case (state_q)
          S_R: begin
            hr_d    = in_data;
            state_d = S_G;
          end
          S_G: begin
            hg_d    = in_data;
            state_d = S_B;
          end
          S_B: begin
            color_d = '{hr_q, hg_q, in_data};
            b_acc   = 1'b1;
            state_d = S_R;
          end
          default: begin
            state_d = S_R;
          end
        endcase
      end
    end else if (state_q != S_R && state_q != S_G && state_q != S_B) begin
      // Unused encoding: recover to the start of a pixel.
      state_d = S_R;
    end
  end

  // A B accept always refills the slot; that covers the back-to-back case
  // where the old pixel leaves on the same edge the new one arrives.
  always_comb begin
    out_valid_d = out_valid_q;
    if (b_acc) begin
      out_valid_d = 1'b1;
    end else if (out_xfer) begin
      out_valid_d = 1'b0;
    end
  end

  always_comb begin
    pix_cnt_d = pix_cnt_q;
    if (out_xfer) begin
      pix_cnt_d = pix_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_R;
      hr_q        <= 8'h00;
      hg_q        <= 8'h00;
      color_q     <= '{8'h00, 8'h00, 8'h00};
      out_valid_q <= 1'b0;
      pix_cnt_q   <= '0;
      sof_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hr_q        <= hr_d;
      hg_q        <= hg_d;
      color_q     <= color_d;
      out_valid_q <= out_valid_d;
      pix_cnt_q   <= pix_cnt_d;
      sof_err_q   <= sof_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign color     = color_q;
  assign pix_cnt   = pix_cnt_q;
  assign state_dbg = state_q;

`ifdef COLOR_PACK_SOF_EN
  assign sof_err = sof_err_q;
`else
  // Without SOF support no partial pixel is ever discarded.
  logic unused_sof_err;
  assign unused_sof_err = sof_err_q;
`endif

endmodule

// File: tb/tb_color_pack.sv
// tb_color_pack
//   Self-checking bench for color_pack. A reference model groups accepted
//   bytes into pixels and keeps them in an expected queue; DUT outputs are
//   compared every cycle on the falling clock edge.
module tb_color_pack;
  import color_pack_pkg::*;

  localparam int CNT_W = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_data;
  logic             out_valid;
  logic             out_ready;
  t_color           color;
  logic [CNT_W-1:0] pix_cnt;
  logic [1:0]       state_dbg;
`ifdef COLOR_PACK_SOF_EN
  logic             in_sof;
  logic             sof_err;
`endif

  color_pack #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
`ifdef COLOR_PACK_SOF_EN
    .in_sof    (in_sof),
    .sof_err   (sof_err),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .color     (color),
    .pix_cnt   (pix_cnt),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard / model ----------------
  int n_tests = 0;
  int n_fail  = 0;

  logic [23:0] exp_q[$];   // pixels awaiting hand-off, oldest first
  int          nbytes;     // bytes collected toward the current pixel
  logic [7:0]  part_r;
  logic [7:0]  part_g;
  int          exp_cnt;
  bit          exp_sof_err;
  bit          last_acc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    nbytes      = 0;
    part_r      = 8'h00;
    part_g      = 8'h00;
    exp_cnt     = 0;
    exp_sof_err = 1'b0;
    last_acc    = 1'b0;
  endtask

  task automatic set_sof(input bit sof);
`ifdef COLOR_PACK_SOF_EN
    in_sof = sof;
`else
    if (sof) $display("note: sof requested without SOF support");
`endif
  endtask

  // ---------------- driver ----------------
  // One clock cycle: drive after the rising edge, check and advance the
  // model on the falling edge (the transfer happens on the next rising edge).
  task automatic cycle(input bit v, input logic [7:0] d, input bit sof, input bit ordy);
    bit exp_ready;
    @(posedge clk);
    #1;
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    set_sof(sof);
    @(negedge clk);

    // Only a completing B beat with a stalled full output must wait.
    exp_ready = (nbytes < 2) || (exp_q.size() == 0) || ordy || sof;
    chk("in_ready",  {31'd0, in_ready},  {31'd0, exp_ready});
    chk("out_valid", {31'd0, out_valid}, {31'd0, (exp_q.size() != 0)});
    if (exp_q.size() != 0)
      chk("color", {8'h00, color.r, color.g, color.b}, {8'h00, exp_q[0]});
    chk("pix_cnt", {{(32-CNT_W){1'b0}}, pix_cnt}, exp_cnt);
`ifdef COLOR_PACK_SOF_EN
    chk("sof_err", {31'd0, sof_err}, {31'd0, exp_sof_err});
`endif

    exp_sof_err = 1'b0;
    if (exp_q.size() != 0 && ordy) begin
      void'(exp_q.pop_front());
      exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
    end
    last_acc = v && exp_ready;
    if (last_acc) begin
      if (sof) begin
        if (nbytes != 0) exp_sof_err = 1'b1;
        part_r = d;
        nbytes = 1;
      end else if (nbytes == 0) begin
        part_r = d;
        nbytes = 1;
      end else if (nbytes == 1) begin
        part_g = d;
        nbytes = 2;
      end else begin
        exp_q.push_back({part_r, part_g, d});
        nbytes = 0;
      end
    end
  endtask

  // Present one byte until it is accepted (bounded).
  task automatic send(input logic [7:0] d, input bit sof, input bit ordy);
    int tries;
    tries = 0;
    do begin
      cycle(1'b1, d, sof, ordy);
      tries++;
    end while (!last_acc && tries < 50);
    if (!last_acc) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n, input bit ordy);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, ordy);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    set_sof(1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_pix_cnt",   {{(32-CNT_W){1'b0}}, pix_cnt}, 32'd0);
    chk("rst_in_ready",  {31'd0, in_ready}, 32'd1);
    chk("rst_color",     {8'h00, color.r, color.g, color.b}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    do_reset();

    // Basic stream 0x01..0x06 with the sink always ready.
    for (int i = 1; i <= 6; i++) send(8'(i), 1'b0, 1'b1);
    idle(3, 1'b1);
    chk("two_pixels_cnt", {{(32-CNT_W){1'b0}}, pix_cnt}, 32'd2);

    // Output stall: R and G still accepted, B held off until the sink drains.
    do_reset();
    send(8'h01, 1'b0, 1'b1);
    send(8'h02, 1'b0, 1'b1);
    send(8'h03, 1'b0, 1'b1);
    send(8'h07, 1'b0, 1'b0);
    send(8'h08, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'h09, 1'b0, 1'b0);
    chk("stall_held_b", {31'd0, last_acc}, 32'd0);
    cycle(1'b1, 8'h09, 1'b0, 1'b1);
    chk("stall_release_acc", {31'd0, last_acc}, 32'd1);
    idle(3, 1'b1);

    // Continuous stream 0x00..0x2F: 16 pixels, also wraps the 2-bit counter.
    do_reset();
    for (int i = 0; i < 48; i++) cycle(1'b1, 8'(i), 1'b0, 1'b1);
    idle(3, 1'b1);
    chk("cont_cnt_wrapped", {{(32-CNT_W){1'b0}}, pix_cnt}, 32'd0);

    // Reset with a pending pixel and a partial one in flight.
    do_reset();
    send(8'h01, 1'b0, 1'b0);
    send(8'h02, 1'b0, 1'b0);
    send(8'h03, 1'b0, 1'b0);
    send(8'hAA, 1'b0, 1'b0);
    send(8'hBB, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_pix_cnt",   {{(32-CNT_W){1'b0}}, pix_cnt}, 32'd0);
    chk("midrst_in_ready",  {31'd0, in_ready}, 32'd1);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    send(8'h11, 1'b0, 1'b1);
    send(8'h22, 1'b0, 1'b1);
    send(8'h33, 1'b0, 1'b1);
    idle(2, 1'b1);

    // Five pixels from reset: pix_cnt walks 1,2,3,0,1.
    do_reset();
    for (int i = 0; i < 15; i++) send(8'(8'h80 + i), 1'b0, 1'b1);
    idle(2, 1'b1);
    chk("five_pix_cnt", {{(32-CNT_W){1'b0}}, pix_cnt}, 32'd1);

`ifdef COLOR_PACK_SOF_EN
    // SOF mid-pixel discards R=0x10, G=0x20.
    do_reset();
    send(8'h10, 1'b0, 1'b1);
    send(8'h20, 1'b0, 1'b1);
    send(8'h30, 1'b1, 1'b1);
    send(8'h40, 1'b0, 1'b1);
    send(8'h50, 1'b0, 1'b1);
    idle(3, 1'b1);
    chk("sof_one_pixel", {{(32-CNT_W){1'b0}}, pix_cnt}, 32'd1);
`endif

    // Randomised traffic with random back-pressure.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bit v;
      bit ordy;
      bit sof;
      v    = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
`ifdef COLOR_PACK_SOF_EN
      sof  = ($urandom_range(0, 15) == 0);
`else
      sof  = 1'b0;
`endif
      cycle(v, 8'($urandom_range(0, 255)), sof, ordy);
    end
    idle(4, 1'b1);
    chk("final_drained", {31'd0, out_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the bench always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/color_pack.md
# color_pack

Byte-stream-to-struct assembler for the RGB pixel path. It accepts 8-bit colour components one per beat, in the order R, G, B, over a valid/ready handshake. It emits one `t_color` unpacked struct (`r`, `g`, `b`, each `logic [7:0]`) per three accepted beats over a second valid/ready handshake. It is the packing counterpart of the block that splits `t_color` into separate registered r/g/b vectors, and sits between a byte-wide source (link or memory reader) and struct-consuming RTL.

## Interface
Parameters:
- `CNT_W`, default 16: width of the emitted-pixel counter `pix_cnt`.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  source has a component byte.
- `in_ready`  out  1  block accepts the byte this cycle.
- `in_data`  in  8  component byte.
- `in_sof`  in  1  start of pixel; byte is R. Present only with `COLOR_PACK_SOF_EN`.
- `out_valid`  out  1  `color` holds a complete pixel.
- `out_ready`  in  1  sink takes the pixel this cycle.
- `color`  out  t_color  assembled pixel.
- `pix_cnt`  out  CNT_W  count of pixels handed off (`out_valid && out_ready`).
- `sof_err`  out  1  one-cycle pulse when a partial pixel is discarded. Present only with `COLOR_PACK_SOF_EN`.

## Operation
- Input transfer: `in_valid && in_ready` on a rising edge. Output transfer: `out_valid && out_ready`.
- FSM states: `S_R`, `S_G`, `S_B`. Reset state is `S_R`.
  - `S_R`: accepted byte goes to holding reg `hr`; next state `S_G`.
  - `S_G`: accepted byte goes to holding reg `hg`; next state `S_B`.
  - `S_B`: accepted byte completes the pixel. Load `color <= '{hr, hg, in_data}`, set `out_valid`, next state `S_R`.
  - No accept: state holds.
- `in_ready`:
  - 1 in `S_R` and `S_G`. The holding registers are independent of `color`, so R and G are taken while a previous pixel is still stalled at the output.
  - `!out_valid || out_ready` in `S_B`.
- `out_valid`:
  - Set on the B accept.
  - Cleared on an output transfer with no simultaneous B accept.
  - Output transfer and B accept in the same cycle: `out_valid` stays 1 and `color` takes the new pixel, giving back-to-back pixels with no bubble.
- `color` is stable while `out_valid && !out_ready`.
- `pix_cnt` increments by 1 per output transfer and wraps from 2^CNT_W−1 to 0.
- Reset mid-operation: partial pixel discarded, pending output dropped, all state returns to reset values immediately.
- Reset values: `in_ready` 1 (state `S_R`), `out_valid` 0, `color` `'{8'h00, 8'h00, 8'h00}`, `hr`/`hg` 0, `pix_cnt` 0, `sof_err` 0.

## Timing
- Latency: `out_valid` rises on the edge that accepts B; it is visible the cycle after the B beat.
- Peak throughput: 1 pixel per 3 cycles with continuous `in_valid` and `out_ready`.
- `in_ready` in `S_B` depends combinationally on `out_ready`, and on `in_sof` when SOF is enabled. There is no combinational path from `in_valid` or `in_data` to any output.
- `color`, `out_valid`, `pix_cnt` and `sof_err` are registered.

## Configuration
- `COLOR_PACK_SOF_EN` defined: ports `in_sof` and `sof_err` exist.
  - A beat with `in_sof=1` is always stored as R and moves the FSM to `S_G`.
  - `in_ready` is forced to 1 when `in_sof=1`, in any state.
  - An SOF accept in `S_G` or `S_B` discards `hr`/`hg` and pulses `sof_err` for one cycle.
  - A beat with `in_sof=0` in `S_R` is accepted, stored as R, and raises no error.
- `COLOR_PACK_SOF_EN` undefined: neither port exists. Strict R→G→B rotation from reset, no resynchronisation.

## Test plan
- Reset, then stream bytes 0x01..0x06 with `out_ready=1` → `color` `'{01,02,03}` one cycle after the 3rd beat, then `'{04,05,06}`; `pix_cnt`=2.
- Hold `out_ready=0` after the first pixel, keep sending 0x07, 0x08, 0x09 → 0x07 and 0x08 accepted; `in_ready`=0 on 0x09; `color` stays `'{01,02,03}`. Raise `out_ready` → 0x09 accepted in the same cycle; next `color` `'{07,08,09}` with no `out_valid` gap.
- Continuous input of 0x00..0x2F with `out_ready=1` → 16 pixels, each 3 cycles apart; pixel n is `'{3n, 3n+1, 3n+2}`.
- Assert `rst` after R=0xAA and G=0xBB, then send 0x11, 0x22, 0x33 → first pixel `'{11,22,33}`; `out_valid` and `pix_cnt` are 0 during reset.
- `CNT_W=2`, emit 5 pixels → `pix_cnt` sequence 1,2,3,0,1.
- `COLOR_PACK_SOF_EN`: send R=0x10, G=0x20, then 0x30 with `in_sof=1`, then 0x40, 0x50 → `sof_err` pulses once; output `'{30,40,50}`; no pixel containing 0x10.
